// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch stage. Owns the fetch PC, drives a synchronous
//            instruction BRAM (one-cycle read latency) and buffers returned
//            words in a small circular queue that feeds decode through a
//            valid/ready handshake. A branch redirects the PC and flushes the
//            queue and any outstanding fetch.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction BRAM
  output logic                  imem_en,
  output logic [ADDR_WIDTH-3:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  // Redirect from the branch unit
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  // Decode handshake
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic [ADDR_WIDTH-1:0] instr_pc4,
  output logic                  instr_valid,
  input  logic                  instr_ready
);

  localparam int                    PTR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                    CNT_W        = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]      C_LAST_PTR   = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]      C_PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]      C_CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W:0]        C_CREDIT_MAX = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_PC_STEP    = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] C_RESET_PC   = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  // Fetch-side state
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight;
  logic [ADDR_WIDTH-1:0] r_inflight_pc;

  // Instruction queue (circular buffer)
  logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_pc    [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  // Combinational control
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [CNT_W:0]        w_credit;
  logic [PTR_W-1:0]      w_head_next;
  logic [PTR_W-1:0]      w_tail_next;
  logic                  w_unused_tgt_lsbs;

  // The target's byte-offset bits are architecturally ignored.
  assign w_unused_tgt_lsbs = ^branch_target[1:0];

  // Queue is non-empty whenever count is non-zero; branch blocks consumption.
  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready && !branch;

  // The word returning from the BRAM is only kept when no branch kills it.
  assign w_push      = r_inflight && !branch;

  // Credit: queued words plus the outstanding fetch, minus the word leaving
  // this cycle, must leave room for the new fetch. pop implies count >= 1, so
  // the subtraction cannot wrap.
  assign w_credit    = {1'b0, r_count}
                     + {{CNT_W{1'b0}}, r_inflight}
                     - {{CNT_W{1'b0}}, w_pop};
  assign w_issue     = !rst && !branch && (w_credit < C_CREDIT_MAX);

  assign imem_en     = w_issue;
  assign imem_addr   = r_fetch_pc[ADDR_WIDTH-1:2];

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  assign w_head_next = (r_head == C_LAST_PTR) ? '0 : r_head + C_PTR_ONE;
  assign w_tail_next = (r_tail == C_LAST_PTR) ? '0 : r_tail + C_PTR_ONE;

  // Head-of-queue outputs are forced to zero while the queue is empty.
  assign instr       = instr_valid ? r_q_instr[r_head] : '0;
  assign instr_pc    = instr_valid ? r_q_pc[r_head] : '0;
  assign instr_pc4   = instr_valid ? (r_q_pc[r_head] + C_PC_STEP) : '0;

  // Fetch PC, outstanding-fetch tracking, and queue pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= C_RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else if (branch) begin
      // Redirect: drop the outstanding fetch and everything queued.
      r_fetch_pc    <= {branch_target[ADDR_WIDTH-1:2], 2'b00};
      r_inflight    <= 1'b0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + C_PC_STEP;
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) begin
        r_tail <= w_tail_next;
      end
      if (w_pop) begin
        r_head <= w_head_next;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: written at the tail when a surviving BRAM word returns.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_q_instr[r_tail] <= imem_rdata;
      r_q_pc[r_tail]    <= r_inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. Stimulus loads the
//            expected PC stream into a scoreboard queue; a negedge monitor
//            pops and compares each word accepted by decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch = 1'b0;
  logic [31:0] branch_target = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_en;
  logic [29:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_valid;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;
  logic [31:0] frz_pc;
  logic [31:0] frz_instr;
  int          pulses;

  // 100 MHz clock
  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (2),
    .RESET_PC   (32'h0000_0100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch        (branch),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_pc4     (instr_pc4),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  // Synchronous BRAM model: word i holds 0xA000_0000 + i.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'hA000_0000 + {2'b00, imem_addr};
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hA000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Replace the expected stream with n consecutive PCs from start (wrapping).
  task automatic load_stream(input logic [31:0] start, input int n);
    logic [31:0] p;
    p = start;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // One cycle: drive inputs just after the edge, return after the monitor ran.
  task automatic cyc(input logic r, input logic rdy, input logic b, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst           = r;
    instr_ready   = rdy;
    branch        = b;
    branch_target = tgt;
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every accepted word; idle outputs must be 0.
  always @(negedge clk) begin
    if (!rst) begin
      if (instr_valid && instr_ready && !branch) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got pc %h with nothing expected", instr_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          check32("sb_pc", instr_pc, mon_pc);
          check32("sb_instr", instr, word_at(mon_pc));
          check32("sb_pc4", instr_pc4, mon_pc + 32'd4);
        end
      end
      if (!instr_valid) begin
        check32("idle_instr", instr, 32'h0);
        check32("idle_pc", instr_pc, 32'h0);
        check32("idle_pc4", instr_pc4, 32'h0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset ----------------
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check32("rst_valid", {31'b0, instr_valid}, 32'h0);
    check32("rst_imem_en", {31'b0, imem_en}, 32'h0);
    check32("rst_instr", instr, 32'h0);
    check32("rst_pc", instr_pc, 32'h0);
    check32("rst_pc4", instr_pc4, 32'h0);

    // ---------------- straight line ----------------
    load_stream(32'h100, 200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  // R
    check32("r_imem_en", {31'b0, imem_en}, 32'h1);
    check32("r_imem_addr", {2'b0, imem_addr}, 32'h40);
    check32("r_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  // R+1
    check32("r1_valid", {31'b0, instr_valid}, 32'h0);
    check32("r1_imem_addr", {2'b0, imem_addr}, 32'h41);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);  // R+2
    check32("r2_valid", {31'b0, instr_valid}, 32'h1);
    check32("r2_pc", instr_pc, 32'h100);
    check32("r2_instr", instr, 32'hA000_0040);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check32("stream_valid", {31'b0, instr_valid}, 32'h1);
    end

    // ---------------- backpressure ----------------
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    frz_pc    = instr_pc;
    frz_instr = instr;
    pulses    = imem_en ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      pulses += imem_en ? 1 : 0;
      check32("bp_pc_frozen", instr_pc, frz_pc);
      check32("bp_instr_frozen", instr, frz_instr);
      check32("bp_valid", {31'b0, instr_valid}, 32'h1);
    end
    checks++;
    if (pulses > 2) begin
      errors++;
      $display("FAIL bp_pulses: got %0d fetches expected at most 2", pulses);
    end
    check32("bp_full_no_fetch", {31'b0, imem_en}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("bp_resume_fetch", {31'b0, imem_en}, 32'h1);
    check32("bp_resume_valid", {31'b0, instr_valid}, 32'h1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      check32("bp_nogap_valid", {31'b0, instr_valid}, 32'h1);
    end

    // ---------------- branch flush (coincident with pop) ----------------
    check32("pre_br_valid", {31'b0, instr_valid}, 32'h1);
    load_stream(32'h200, 100);
    cyc(1'b0, 1'b1, 1'b1, 32'h203);  // B
    check32("br_imem_en", {31'b0, imem_en}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);    // B+1
    check32("br1_valid", {31'b0, instr_valid}, 32'h0);
    check32("br1_imem_en", {31'b0, imem_en}, 32'h1);
    check32("br1_imem_addr", {2'b0, imem_addr}, 32'h80);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);    // B+2
    check32("br2_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);    // B+3
    check32("br3_valid", {31'b0, instr_valid}, 32'h1);
    check32("br3_pc", instr_pc, 32'h200);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // ---------------- branch while idle (queue empty, nothing in flight) ----------------
    load_stream(32'h300, 100);
    cyc(1'b0, 1'b1, 1'b1, 32'h300);  // leaves count = 0, inflight = 0
    load_stream(32'h500, 100);
    cyc(1'b0, 1'b1, 1'b1, 32'h501);  // B'
    check32("idle_br_imem_en", {31'b0, imem_en}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("idle_br1_valid", {31'b0, instr_valid}, 32'h0);
    check32("idle_br1_addr", {2'b0, imem_addr}, 32'h140);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("idle_br2_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("idle_br3_valid", {31'b0, instr_valid}, 32'h1);
    check32("idle_br3_pc", instr_pc, 32'h500);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // ---------------- wrap-around ----------------
    load_stream(32'hFFFF_FFF8, 50);
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
    check32("wrap_pc4", instr_pc4, 32'h0000_0000);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("wrap_pc2", instr_pc, 32'h0000_0000);
    check32("wrap_instr2", instr, 32'hA000_0000);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    // ---------------- reset mid-stream ----------------
    check32("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
    exp_q.delete();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);    // rst high one cycle
    load_stream(32'h100, 100);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);    // first cycle with rst low
    check32("mrst_valid", {31'b0, instr_valid}, 32'h0);
    check32("mrst_instr", instr, 32'h0);
    check32("mrst_pc", instr_pc, 32'h0);
    check32("mrst_pc4", instr_pc4, 32'h0);
    check32("mrst_imem_en", {31'b0, imem_en}, 32'h1);
    check32("mrst_imem_addr", {2'b0, imem_addr}, 32'h40);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("mrst1_valid", {31'b0, instr_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    check32("mrst2_valid", {31'b0, instr_valid}, 32'h1);
    check32("mrst2_pc", instr_pc, 32'h100);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
